mem_responder: RTL and testbench
================================

# mem_responder

Clocked target for the SoC data bus: accepts byte, halfword and word read/write requests from a bus initiator (CPU or sequencer) through a valid/ready handshake and serves them from an internal byte-addressed, little-endian RAM. It returns data and an exception flag with fixed latency, and sits behind the data bus decode as the memory end of that interface.

## Interface
- MEM_WORDS, 1024: RAM depth in 32-bit words; valid byte addresses 0 .. MEM_WORDS*4-1.
- ADDR_WIDTH, 32: width of the request address.
- clk  in  1  bus clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  request valid.
- ready  out  1  responder can accept a request this cycle.
- rw  in  1  0 = read, 1 = write.
- len  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- addr  in  ADDR_WIDTH  byte address.
- wdata  in  32  write data, right-aligned (byte in [7:0], half in [15:0]).
- ack  out  1  one-cycle response strobe.
- rdata  out  32  read data, zero-extended, right-aligned; valid while ack=1.
- exception  out  1  access faulted; valid while ack=1.

## Operation
- States: IDLE, ACCESS, RESP. Reset enters IDLE.
- IDLE: ready=1. On req=1, capture rw/len/addr/wdata, go to ACCESS. req may drop after the accepting edge.
- ACCESS: ready=0. Fault check on the captured request:
  - addr > MEM_WORDS*4-1: fault.
  - len=11: fault.
  - Misalignment: see Configuration.
- ACCESS, no fault:
  - Write: commit the selected byte lanes of word addr[..:2].
  - Read: register the lanes selected by addr[1:0] and len, shifted down to bit 0, upper bits zero.
- ACCESS, fault: no RAM write; rdata 0; exception set. Then go to RESP.
- RESP: ack=1 for exactly one cycle with rdata/exception. Go to IDLE.
  - Writes return rdata=0.
- Lane mapping: byte n of a word = bits [8n+7:8n] (little-endian).
- RAM contents are not initialised or cleared by reset.

## Timing
- Reset values: ready=1, ack=0, rdata=0, exception=0, state IDLE.
- Accept edge N (req=1, ready=1). ACCESS during cycle N+1. ack=1 during cycle N+2. ready=1 again in cycle N+3.
- Throughput: one request per 3 cycles.
- req=1 while ready=0 is ignored; no queueing.
- rdata/exception hold their values after ack falls until the next RESP. The initiator samples them only when ack=1.
- Read after a write to the same address returns the new data. The write commits in ACCESS, before the read's ACCESS.
- Reset asserted in ACCESS or RESP: immediate return to IDLE. ack/exception/rdata cleared asynchronously. A write still in ACCESS is discarded; a write already committed remains.

## Configuration
- BUS_MISALIGN_TRAP_EN defined: misaligned accesses fault with exception=1 and no RAM change.
  - Halfword with addr[0]=1 is misaligned.
  - Word with addr[1:0]≠0 is misaligned.
- BUS_MISALIGN_TRAP_EN undefined: misaligned accesses never fault.
  - Halfword address is aligned down (addr[0] ignored).
  - Word address is aligned down (addr[1:0] ignored).
  - Range and len=11 checks still apply.

## Test plan
- Reset, then word write 0xDEADBEEF at 0x10, then byte reads at 0x10..0x13: rdata 0xEF, 0xBE, 0xAD, 0xDE. Each ack comes exactly 2 cycles after accept; exception=0.
- Halfword write 0x1234 at 0x22 over prior word 0xAAAAAAAA at 0x20, then word read at 0x20: rdata 0x1234AAAA.
- Word read at MEM_WORDS*4 (4096 by default): ack with exception=1, rdata 0. Same for len=11 at 0x0. A following write to 4096 leaves RAM unchanged.
- Word read at 0x12 (memory at 0x10 holds 0xDEADBEEF):
  - With BUS_MISALIGN_TRAP_EN: exception=1.
  - Without it: exception=0, rdata 0xDEADBEEF.
- req held high continuously: accepts only when ready=1, one every 3 cycles. ack pulses exactly one cycle each; no request is lost or duplicated.
- Assert rst_n=0 during ACCESS of a write of 0x55 to 0x40 (prior value 0x00): ack stays 0, outputs reset values. After release, ready=1 and a byte read at 0x40 returns 0x00.

Source files
------------

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - byte/halfword/word bus target backed by an internal little-endian RAM
//
// Purpose: accepts one read/write request through req/ready, checks it in an
// ACCESS cycle, and returns data plus an exception flag on a one-cycle ack.
// Fixed latency: accept edge N, ACCESS in cycle N+1, ack in cycle N+2.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req / ready     request valid / responder idle and accepting
//   rw              0 = read, 1 = write
//   len             00 byte, 01 halfword, 10 word, 11 reserved (faults)
//   addr            byte address
//   wdata           right-aligned write data
//   ack             one-cycle response strobe
//   rdata           right-aligned, zero-extended read data (0 for writes/faults)
//   exception       access faulted
//
// Option macro: BUS_MISALIGN_TRAP_EN - when defined, misaligned halfword/word
// accesses fault; when undefined, they are silently aligned down.
module mem_responder #(
    parameter int MEM_WORDS  = 1024,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    output logic                  ready,
    input  logic                  rw,
    input  logic [1:0]            len,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic                  ack,
    output logic [31:0]           rdata,
    output logic                  exception
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(MEM_WORDS * 4 - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic                  rw_q;
    logic [1:0]            len_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q, rdata_d;
    logic                  exc_q, exc_d;

    logic [31:0] mem [MEM_WORDS];

    logic             fault;
    logic [1:0]       off;
    logic [3:0]       lane_base;
    logic [3:0]       lanes;
    logic [31:0]      wshift;
    logic [31:0]      rword;
    logic [31:0]      rshift;
    logic [31:0]      rsel;
    logic [IDX_W-1:0] word_idx;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ready = 1'b0;
        ack   = 1'b0;
        case (state_q)
            IDLE:    ready = 1'b1;
            RESP:    ack   = 1'b1;
            default: ;
        endcase
    end

    // ---------------- fault check and effective byte offset ----------------
    always_comb begin
        fault = 1'b0;
        off   = addr_q[1:0];
        if ((addr_q > MAX_ADDR) || (len_q == 2'b11)) begin
            fault = 1'b1;
        end
`ifdef BUS_MISALIGN_TRAP_EN
        if ((len_q == 2'b01) && addr_q[0]) begin
            fault = 1'b1;
        end
        if ((len_q == 2'b10) && (addr_q[1:0] != 2'b00)) begin
            fault = 1'b1;
        end
`else
        // Misaligned accesses are aligned down to their natural boundary.
        if (len_q == 2'b01) begin
            off[0] = 1'b0;
        end
        if (len_q == 2'b10) begin
            off = 2'b00;
        end
`endif
    end

    // ---------------- lane selection ----------------
    always_comb begin
        case (len_q)
            2'b00:   lane_base = 4'b0001;
            2'b01:   lane_base = 4'b0011;
            default: lane_base = 4'b1111;
        endcase
        lanes    = lane_base << off;
        wshift   = wdata_q << {off, 3'b000};
        // Out-of-range addresses index a truncated (in-range) word; the result
        // is discarded by the fault path.
        word_idx = addr_q[IDX_W+1:2];
        rword    = mem[word_idx];
        rshift   = rword >> {off, 3'b000};
        case (len_q)
            2'b00:   rsel = {24'h0, rshift[7:0]};
            2'b01:   rsel = {16'h0, rshift[15:0]};
            default: rsel = rshift;
        endcase
    end

    // ---------------- RAM (not reset) ----------------
    // state_q drops to IDLE asynchronously on reset, so a write still in
    // ACCESS when reset arrives never commits.
    always_ff @(posedge clk) begin
        if ((state_q == ACCESS) && rw_q && !fault) begin
            for (int b = 0; b < 4; b++) begin
                if (lanes[b]) begin
                    mem[word_idx][8*b +: 8] <= wshift[8*b +: 8];
                end
            end
        end
    end

    // ---------------- response next state ----------------
    always_comb begin
        rdata_d = rdata_q;
        exc_d   = exc_q;
        if (state_q == ACCESS) begin
            exc_d   = fault;
            rdata_d = (fault || rw_q) ? 32'h0 : rsel;
        end
    end

    // ---------------- request capture and response registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q    <= 1'b0;
            len_q   <= 2'b00;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            exc_q   <= 1'b0;
        end else begin
            if ((state_q == IDLE) && req) begin
                rw_q    <= rw;
                len_q   <= len;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            rdata_q <= rdata_d;
            exc_q   <= exc_d;
        end
    end

    assign rdata     = rdata_q;
    assign exception = exc_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder against a byte-level reference model
module tb_mem_responder;

    localparam int MEM_WORDS = 1024;
    localparam int MEM_BYTES = MEM_WORDS * 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        ready;
    logic        rw = 1'b0;
    logic [1:0]  len = 2'b00;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        ack;
    logic [31:0] rdata;
    logic        exception;

    int checks = 0;
    int failures = 0;

    logic [7:0] ref_mem [MEM_BYTES];

    mem_responder #(.MEM_WORDS(MEM_WORDS), .ADDR_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .ready     (ready),
        .rw        (rw),
        .len       (len),
        .addr      (addr),
        .wdata     (wdata),
        .ack       (ack),
        .rdata     (rdata),
        .exception (exception)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Byte-granular memory model: a request touches 1, 2 or 4 consecutive bytes.
    task automatic model_access(input bit rw_v, input logic [1:0] len_v, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd, output logic exc);
        int n;
        longint ea;
        rd  = 32'h0;
        exc = 1'b0;
        n = (len_v == 2'd0) ? 1 : (len_v == 2'd1) ? 2 : 4;
        if ((longint'(a) > MEM_BYTES - 1) || (len_v == 2'd3)) exc = 1'b1;
`ifdef BUS_MISALIGN_TRAP_EN
        else if ((a % n) != 0) exc = 1'b1;
`endif
        if (!exc) begin
            ea = longint'(a) - longint'(a % n);
            for (int i = 0; i < n; i++) begin
                if (rw_v) ref_mem[int'(ea) + i] = wd[8*i +: 8];
                else      rd[8*i +: 8] = ref_mem[int'(ea) + i];
            end
        end
    endtask

    // One full transaction with latency checks: ACCESS cycle has no ack,
    // next cycle has ack with model data, then back to idle.
    task automatic xact(input bit rw_v, input logic [1:0] len_v, input logic [31:0] a,
                        input logic [31:0] wd, input string tag);
        logic [31:0] er;
        logic        ee;
        int guard;
        guard = 0;
        @(negedge clk);
        while (!ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, " ready"}, {31'h0, ready}, 32'h1);
        req = 1'b1; rw = rw_v; len = len_v; addr = a; wdata = wd;
        @(negedge clk);
        req = 1'b0;
        chk({tag, " access ack/ready"}, {30'h0, ack, ready}, 32'h0);
        @(negedge clk);
        model_access(rw_v, len_v, a, wd, er, ee);
        chk({tag, " ack"}, {31'h0, ack}, 32'h1);
        chk({tag, " rdata"}, rdata, er);
        chk({tag, " exception"}, {31'h0, exception}, {31'h0, ee});
        @(negedge clk);
        chk({tag, " idle ack/ready"}, {30'h0, ack, ready}, 32'h1);
    endtask

    initial begin
        logic [31:0] exp_q [$];
        logic [31:0] er;
        logic        ee;
        logic [31:0] a;
        logic [1:0]  l;
        bit          w;
        int accepts, acks, last_ack, r;

        // ---- reset values ----
        repeat (3) @(negedge clk);
        chk("reset ready", {31'h0, ready}, 32'h1);
        chk("reset ack", {31'h0, ack}, 32'h0);
        chk("reset rdata", rdata, 32'h0);
        chk("reset exception", {31'h0, exception}, 32'h0);
        rst_n = 1'b1;

        // ---- word write, byte reads, little-endian lanes ----
        xact(1, 2'd2, 32'h10, 32'hDEADBEEF, "w10");
        xact(0, 2'd0, 32'h10, 32'h0, "rb10");
        xact(0, 2'd0, 32'h11, 32'h0, "rb11");
        xact(0, 2'd0, 32'h12, 32'h0, "rb12");
        xact(0, 2'd0, 32'h13, 32'h0, "rb13");

        // ---- halfword merge ----
        xact(1, 2'd2, 32'h20, 32'hAAAAAAAA, "w20");
        xact(1, 2'd1, 32'h22, 32'h00001234, "wh22");
        xact(0, 2'd2, 32'h20, 32'h0, "rw20");

        // ---- faults: range, len=11, and faulted write leaves RAM unchanged ----
        xact(1, 2'd2, 32'h0, 32'h0BADF00D, "w0");
        xact(0, 2'd2, MEM_BYTES, 32'h0, "r_oor");
        xact(0, 2'd3, 32'h0, 32'h0, "r_len3");
        xact(1, 2'd2, MEM_BYTES, 32'hFFFFFFFF, "w_oor");
        xact(0, 2'd2, 32'h0, 32'h0, "r0_after_oor");
        xact(0, 2'd2, MEM_BYTES - 4, 32'h0, "r_last_prefault");
        xact(1, 2'd0, MEM_BYTES - 1, 32'h0000005A, "wb_last");
        xact(0, 2'd0, MEM_BYTES - 1, 32'h0, "rb_last");

        // ---- misaligned word and halfword ----
        xact(0, 2'd2, 32'h12, 32'h0, "rw12_misalign");
        xact(0, 2'd1, 32'h13, 32'h0, "rh13_misalign");
        xact(1, 2'd1, 32'h21, 32'h0000BEEF, "wh21_misalign");
        xact(0, 2'd2, 32'h20, 32'h0, "rw20_after_mis");

        // ---- req held high: one accept per 3 cycles, no loss/duplication ----
        for (int i = 0; i < 16; i++) xact(1, 2'd2, 32'h100 + 4*i, $urandom, "prefill");
        accepts = 0; acks = 0; last_ack = -100;
        req = 1'b1; rw = 1'b0; len = 2'd2;
        for (int c = 0; c < 30; c++) begin
            if (ack) begin
                acks++;
                if (last_ack >= 0) chk("burst ack spacing", c - last_ack, 3);
                last_ack = c;
                if (exp_q.size() > 0) chk("burst rdata", rdata, exp_q.pop_front());
                else chk("burst spurious ack", {31'h0, ack}, 32'h0);
            end
            if (ready) begin
                a = 32'h100 + 4 * (accepts % 16);
                addr = a;
                model_access(0, 2'd2, a, 32'h0, er, ee);
                exp_q.push_back(er);
                accepts++;
            end
            @(negedge clk);
        end
        req = 1'b0;
        repeat (4) begin
            if (ack) acks++;
            @(negedge clk);
        end
        chk("burst accepts", accepts, 10);
        chk("burst acks", acks, accepts);

        // ---- randomized mix against the model ----
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = MEM_BYTES + $urandom_range(0, 15);
            else if (r == 1) a = 32'hFFFFFFF0 | $urandom_range(0, 15);
            else             a = 32'h100 + $urandom_range(0, 63);
            l = (r == 2) ? 2'd3 : 2'($urandom_range(0, 2));
            w = 1'($urandom_range(0, 1));
            xact(w, l, a, $urandom, $sformatf("rnd%0d", i));
        end

        // ---- reset during ACCESS of a write discards it ----
        xact(1, 2'd0, 32'h40, 32'h00000000, "w40_zero");
        xact(0, 2'd0, 32'h10, 32'h0, "r10_nonzero");
        @(negedge clk);
        req = 1'b1; rw = 1'b1; len = 2'd0; addr = 32'h40; wdata = 32'h55;
        @(posedge clk);
        #2;
        req = 1'b0;
        chk("rst in access state", {31'h0, ready}, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("rst ready", {31'h0, ready}, 32'h1);
        chk("rst ack", {31'h0, ack}, 32'h0);
        chk("rst rdata", rdata, 32'h0);
        chk("rst exception", {31'h0, exception}, 32'h0);
        @(negedge clk);
        chk("rst hold ack", {31'h0, ack}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-rst ready", {31'h0, ready}, 32'h1);
        xact(0, 2'd0, 32'h40, 32'h0, "r40_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
